if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of instruction address.
REQ-002 Parameter INST_WIDTH, default 32: width of instruction word.
REQ-003 Parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-004 Parameter CNT_WIDTH, default $clog2(DEPTH)+1: occupancy counter width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 rdy  input  1  global enable; low freezes all state.
REQ-008 if_valid  input  1  IF presents an instruction this cycle.
REQ-009 if_pc  input  ADDR_WIDTH  PC of the presented instruction.
REQ-010 if_inst  input  INST_WIDTH  presented instruction word.
REQ-011 if_ready  output  1  queue can accept an instruction (not full).
REQ-012 jump_enable  input  1  branch/jump redirect; flushes queue.
REQ-013 id_stall  input  1  ID cannot consume the head this cycle.
REQ-014 id_valid  output  1  head entry present.
REQ-015 id_pc  output  ADDR_WIDTH  PC of head entry.
REQ-016 id_inst  output  INST_WIDTH  instruction of head entry.
REQ-017 count  output  CNT_WIDTH  current occupancy, 0..DEPTH.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH {pc, inst} entries with read pointer, write pointer and occupancy count.
REQ-019 if_ready SHALL equal (count != DEPTH), combinational from registered count.
REQ-020 id_valid SHALL equal (count != 0); id_pc/id_inst SHALL show the head entry when id_valid=1, else zero (bubble).
REQ-021 Enqueue SHALL occur on an edge with rdy=1, rst=0, jump_enable=0, if_valid=1, if_ready=1; entry written at write pointer, pointer +1 mod DEPTH.
REQ-022 Dequeue SHALL occur on an edge with rdy=1, rst=0, jump_enable=0, id_valid=1, id_stall=0; read pointer +1 mod DEPTH.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-024 Enqueue-only: count +1; dequeue-only: count -1.
REQ-025 When full, enqueue SHALL NOT occur even with a same-cycle dequeue (if_ready depends only on count).
REQ-026 When empty, id_stall SHALL be ignored and no dequeue occur; enqueued data SHALL appear on id_* one cycle after the enqueue edge (no bypass).
REQ-027 jump_enable=1 with rdy=1 SHALL clear count and both pointers to 0, discard the same-cycle if_* input and cancel any same-cycle dequeue; id_valid=0 next cycle.
REQ-028 rdy=0 SHALL hold all state, including ignoring jump_enable and if_valid; outputs remain stable.
REQ-029 Pointer wrap-around SHALL be seamless; FIFO order preserved across wrap.
REQ-030 Entry contents SHALL NOT be cleared on flush; only pointers and count reset.

Reset
REQ-031 rst=1 at an edge SHALL set count=0, both pointers=0, regardless of rdy, jump_enable or handshakes; precedence: rst > rdy > jump_enable > enq/deq.
REQ-032 After reset: if_ready=1, id_valid=0, id_pc=0, id_inst=0, count=0.
REQ-033 Reset mid-operation SHALL discard all entries; the next valid output is the first instruction enqueued after rst deasserts.

Verification
REQ-034 Fill: DEPTH=4, id_stall=1, enqueue pc 0x0,0x4,0x8,0xC -> count=4, if_ready=0, fifth if_valid ignored, id_pc=0x0.
REQ-035 Drain order: from full, id_stall=0 for 4 cycles -> id_pc 0x0,0x4,0x8,0xC, then id_valid=0, id_pc=0, count=0.
REQ-036 Wrap: steady enqueue+dequeue for 10 cycles with pc incrementing by 4 -> count constant, output pc sequence contiguous across pointer wrap.
REQ-037 Flush: count=3, jump_enable=1 with if_valid=1 pc 0x100 -> next cycle count=0, id_valid=0; following enqueue of 0x200 appears alone at head.
REQ-038 rdy gating: count=2, rdy=0 with if_valid=1, id_stall=0, jump_enable=1 -> count=2 and id_* unchanged; rdy=1 restores normal operation.
REQ-039 Reset: count=3, rst=1 with if_valid=1 -> count=0, if_ready=1, id_inst=0 next cycle.

Source files
------------

// File: rtl/if_id_queue_if.sv
// IF -> ID instruction queue handshake bundle.
// Fetch side pushes {pc, inst}; decode side pops the head.
interface if_id_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
);
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [INST_WIDTH-1:0] if_inst;
  logic                  if_ready;
  logic                  jump_enable;
  logic                  id_stall;
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [INST_WIDTH-1:0] id_inst;
  logic [CNT_WIDTH-1:0]  count;

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_inst,
    input  jump_enable,
    input  id_stall,
    output if_ready,
    output id_valid,
    output id_pc,
    output id_inst,
    output count
  );

  modport master (
    output if_valid,
    output if_pc,
    output if_inst,
    output jump_enable,
    output id_stall,
    input  if_ready,
    input  id_valid,
    input  id_pc,
    input  id_inst,
    input  count
  );
endinterface

// File: rtl/if_id_queue.sv
// Circular IF/ID instruction queue with flush on redirect.
// No bypass: an enqueued entry is visible on id_* one cycle later.
module if_id_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  if_id_queue_if.slave   q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CNT_WIDTH-1:0] cnt;

  logic not_full;
  logic not_empty;
  logic enq;
  logic deq;
  entry_t head;

  assign not_full  = (cnt != FULL);
  assign not_empty = (cnt != '0);

  // redirect cancels both sides; rdy/rst gate in the state update
  assign enq = q.if_valid & not_full & ~q.jump_enable;
  assign deq = not_empty & ~q.id_stall & ~q.jump_enable;

  assign head = mem[rd_ptr];

  assign q.if_ready = not_full;
  assign q.id_valid = not_empty;
  assign q.id_pc    = not_empty ? head.pc   : '0;
  assign q.id_inst  = not_empty ? head.inst : '0;
  assign q.count    = cnt;

  // pointer and occupancy update: rst > rdy > flush > enq/deq
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (rdy) begin
      if (q.jump_enable) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        unique case ({enq, deq})
          2'b10:   cnt <= cnt + CNT_WIDTH'(1);
          2'b01:   cnt <= cnt - CNT_WIDTH'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // entry storage; contents survive flush and reset
  always_ff @(posedge clk) begin
    if (!rst && rdy && enq) begin
      mem[wr_ptr] <= '{pc: q.if_pc, inst: q.if_inst};
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomized + directed bench for if_id_queue.
// Reference is a plain queue of {pc, inst} with an occupancy count.
module tb_if_id_queue;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b0;

  if_id_queue_if #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW),
    .DEPTH(D), .CNT_WIDTH(CW)
  ) bus ();

  if_id_queue #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW),
    .DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .q(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   occ = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // apply one cycle of stimulus; accepted enqueues go to the scoreboard
  task automatic drive(input bit r, input bit en,
                       input bit v, input logic [AW-1:0] pc,
                       input logic [IW-1:0] inst,
                       input bit j, input bit st);
    @(posedge clk);
    #1;
    rst             = r;
    rdy             = en;
    bus.if_valid    = v;
    bus.if_pc       = pc;
    bus.if_inst     = inst;
    bus.jump_enable = j;
    bus.id_stall    = st;
    started         = 1'b1;
    if (!r && en && !j && v && occ != D) begin
      ent_t e;
      e.pc   = pc;
      e.inst = inst;
      exp_q.push_back(e);
    end
  endtask

  // monitor: check outputs against model, then apply the coming edge
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        bit deq;
        bit enq;
        chk("count", 64'(bus.count), 64'(occ));
        chk("if_ready", 64'(bus.if_ready), 64'(occ != D));
        chk("id_valid", 64'(bus.id_valid), 64'(occ != 0));
        if (occ == 0) begin
          chk("bubble_pc", 64'(bus.id_pc), 64'd0);
          chk("bubble_inst", 64'(bus.id_inst), 64'd0);
        end else if (exp_q.size() > 0) begin
          chk("head_pc", 64'(bus.id_pc), 64'(exp_q[0].pc));
          chk("head_inst", 64'(bus.id_inst),
              64'(exp_q[0].inst));
        end else begin
          chk("scoreboard_empty", 64'(exp_q.size()), 64'(occ));
        end
        if (rst || (rdy && bus.jump_enable)) begin
          exp_q.delete();
          occ = 0;
        end else if (rdy) begin
          deq = (occ != 0) && !bus.id_stall;
          enq = bus.if_valid && (occ != D);
          if (deq && exp_q.size() > 0) void'(exp_q.pop_front());
          occ = occ + int'(enq) - int'(deq);
        end
      end
    end
  end

  function automatic logic [IW-1:0] ins(input logic [AW-1:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h5a5a_0000;
  endfunction

  logic [AW-1:0] p;

  initial begin
    bus.if_valid    = 1'b0;
    bus.if_pc       = '0;
    bus.if_inst     = '0;
    bus.jump_enable = 1'b0;
    bus.id_stall    = 1'b0;

    // reset
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h44, 32'h1, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1);

    // fill with stall, fifth ignored
    for (int i = 0; i < 5; i++) begin
      p = 32'(i * 4);
      drive(0, 1, 1, p, ins(p), 0, 1);
    end
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_head", 64'(bus.id_pc), 64'h0);

    // full with dequeue: no enqueue
    drive(0, 1, 1, 32'h20, ins(32'h20), 0, 0);
    // drain
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);

    // wrap: steady stream
    p = 32'h1000;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1, p, ins(p), 0, i < 2);
      p += 4;
    end
    drive(0, 1, 0, 0, 0, 0, 1);

    // flush with same-cycle input
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      p = 32'h80 + 32'(i * 4);
      drive(0, 1, 1, p, ins(p), 0, 1);
    end
    drive(0, 1, 1, 32'h100, ins(32'h100), 1, 0);
    drive(0, 1, 1, 32'h200, ins(32'h200), 0, 1);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("flush_head", 64'(bus.id_pc), 64'h200);
    chk("flush_count", 64'(bus.count), 64'd1);

    // rdy gating
    drive(0, 1, 1, 32'h204, ins(32'h204), 0, 1);
    drive(0, 0, 1, 32'h208, ins(32'h208), 1, 0);
    drive(0, 0, 1, 32'h20c, ins(32'h20c), 1, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    chk("gate_count", 64'(bus.count), 64'd2);
    drive(0, 1, 0, 0, 0, 0, 0);

    // reset mid-operation
    drive(0, 1, 1, 32'h300, ins(32'h300), 0, 1);
    drive(0, 1, 1, 32'h304, ins(32'h304), 0, 1);
    drive(1, 1, 1, 32'h308, ins(32'h308), 0, 0);
    drive(0, 1, 1, 32'h400, ins(32'h400), 0, 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit en;
      bit v;
      bit j;
      bit st;
      r  = ($urandom_range(99) < 2);
      en = ($urandom_range(99) < 88);
      v  = ($urandom_range(99) < 65);
      j  = ($urandom_range(99) < 5);
      st = ($urandom_range(99) < 40);
      drive(r, en, v, $urandom, $urandom, j, st);
    end
    drive(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
